// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM controller slice.
package vram_pkg;

    localparam int unsigned VRAM_AW    = 10;
    localparam int unsigned VRAM_DW    = 8;
    localparam int unsigned VRAM_DEPTH = 1024;

    typedef enum logic {
        C_IDLE,
        C_RUN
    } clear_state_e;

endpackage

// File: rtl/vram_clear_fsm.sv
// Clear engine: sweeps every VRAM address once, one write request per cycle.
// Only instantiated when VRAM_CLEAR_EN is defined.
module vram_clear_fsm
    import vram_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               we,
    output logic [VRAM_AW-1:0] addr
);

    localparam logic [VRAM_AW-1:0] LAST_ADDR = VRAM_AW'(VRAM_DEPTH - 1);

    clear_state_e       state_q, state_d;
    logic [VRAM_AW-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    // State, address counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state; done is registered so it lines up with the last v_cea.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            C_IDLE: begin
                if (start) begin
                    state_d = C_RUN;
                    cnt_d   = '0;
                end
            end
            C_RUN: begin
                // Counter wraps to 0 naturally; the wrap only ends the sweep.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = C_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    assign busy = (state_q == C_RUN);
    assign we   = (state_q == C_RUN);
    assign addr = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/vram_ctrl.sv
// VRAM controller: arbitrates the write port (clear > CPU) and the read port
// (display > CPU), drives a registered dual-port VRAM interface and returns
// read data three cycles after grant. Optional clear engine: VRAM_CLEAR_EN.
module vram_ctrl
    import vram_pkg::*;
#(
    parameter logic [VRAM_DW-1:0] FILL_CHAR = 8'h20
) (
    input  logic               MEMORY_CLK,
    input  logic               reset,
    input  logic               cpu_wr_req,
    input  logic [VRAM_AW-1:0] cpu_wr_addr,
    input  logic [VRAM_DW-1:0] cpu_wr_data,
    output logic               cpu_wr_ack,
    input  logic               cpu_rd_req,
    input  logic [VRAM_AW-1:0] cpu_rd_addr,
    output logic               cpu_rd_valid,
    output logic [VRAM_DW-1:0] cpu_rd_data,
    input  logic               disp_req,
    input  logic [VRAM_AW-1:0] disp_addr,
    output logic               disp_valid,
    output logic [VRAM_DW-1:0] disp_data,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               v_cea,
    output logic               v_ceb,
    output logic               v_oce,
    output logic               v_reseta,
    output logic               v_resetb,
    output logic [VRAM_AW-1:0] v_ada,
    output logic [VRAM_AW-1:0] v_adb,
    output logic [VRAM_DW-1:0] v_din,
    input  logic [VRAM_DW-1:0] v_dout
);

    logic               clr_busy, clr_done, clr_we;
    logic [VRAM_AW-1:0] clr_addr;

`ifdef VRAM_CLEAR_EN
    vram_clear_fsm u_clear_fsm (
        .clk   (MEMORY_CLK),
        .reset (reset),
        .start (clear_start),
        .busy  (clr_busy),
        .done  (clr_done),
        .we    (clr_we),
        .addr  (clr_addr)
    );
`else
    logic unused_clear;
    assign unused_clear = clear_start ^ (^FILL_CHAR);
    assign clr_busy     = 1'b0;
    assign clr_done     = 1'b0;
    assign clr_we       = 1'b0;
    assign clr_addr     = '0;
`endif

    logic               v_cea_q, v_ceb_q, cpu_wr_ack_q;
    logic [VRAM_AW-1:0] v_ada_q, v_adb_q;
    logic [VRAM_DW-1:0] v_din_q;
    logic               rd1_disp_q, rd1_cpu_q, rd2_disp_q, rd2_cpu_q;
    logic               disp_valid_q, cpu_rd_valid_q;
    logic [VRAM_DW-1:0] disp_data_q, cpu_rd_data_q;

    logic               cpu_wr_gnt, wr_en_d;
    logic [VRAM_AW-1:0] wr_addr_d;
    logic [VRAM_DW-1:0] wr_data_d;
    logic               disp_gnt, cpu_rd_gnt, cpu_rd_pend, rd_en_d;
    logic [VRAM_AW-1:0] rd_addr_d;

    // Write arbitration: clear wins; a CPU write is not re-granted in its ack cycle.
    always_comb begin
        cpu_wr_gnt = cpu_wr_req && !clr_busy && !cpu_wr_ack_q;
        wr_en_d    = clr_we || cpu_wr_gnt;
        wr_addr_d  = v_ada_q;
        wr_data_d  = v_din_q;
        if (clr_we) begin
            wr_addr_d = clr_addr;
            wr_data_d = FILL_CHAR;
        end else if (cpu_wr_gnt) begin
            wr_addr_d = cpu_wr_addr;
            wr_data_d = cpu_wr_data;
        end
    end

    // Read arbitration: display strictly first; CPU held off while its read is in flight.
    always_comb begin
        cpu_rd_pend = rd1_cpu_q || rd2_cpu_q || cpu_rd_valid_q;
        disp_gnt    = disp_req;
        cpu_rd_gnt  = cpu_rd_req && !disp_req && !cpu_rd_pend;
        rd_en_d     = disp_gnt || cpu_rd_gnt;
        rd_addr_d   = v_adb_q;
        if (disp_gnt) begin
            rd_addr_d = disp_addr;
        end else if (cpu_rd_gnt) begin
            rd_addr_d = cpu_rd_addr;
        end
    end

    // Registered VRAM interface plus the grant -> v_ceb -> v_dout -> valid pipeline.
    always_ff @(posedge MEMORY_CLK) begin
        if (reset) begin
            v_cea_q        <= 1'b0;
            v_ceb_q        <= 1'b0;
            cpu_wr_ack_q   <= 1'b0;
            v_ada_q        <= '0;
            v_adb_q        <= '0;
            v_din_q        <= '0;
            rd1_disp_q     <= 1'b0;
            rd1_cpu_q      <= 1'b0;
            rd2_disp_q     <= 1'b0;
            rd2_cpu_q      <= 1'b0;
            disp_valid_q   <= 1'b0;
            cpu_rd_valid_q <= 1'b0;
            disp_data_q    <= '0;
            cpu_rd_data_q  <= '0;
        end else begin
            v_cea_q        <= wr_en_d;
            cpu_wr_ack_q   <= cpu_wr_gnt && !clr_we;
            v_ada_q        <= wr_addr_d;
            v_din_q        <= wr_data_d;
            v_ceb_q        <= rd_en_d;
            v_adb_q        <= rd_addr_d;
            rd1_disp_q     <= disp_gnt;
            rd1_cpu_q      <= cpu_rd_gnt;
            rd2_disp_q     <= rd1_disp_q;
            rd2_cpu_q      <= rd1_cpu_q;
            disp_valid_q   <= rd2_disp_q;
            cpu_rd_valid_q <= rd2_cpu_q;
            if (rd2_disp_q) begin
                disp_data_q <= v_dout;
            end
            if (rd2_cpu_q) begin
                cpu_rd_data_q <= v_dout;
            end
        end
    end

    assign v_cea        = v_cea_q;
    assign v_ceb        = v_ceb_q;
    assign v_ada        = v_ada_q;
    assign v_adb        = v_adb_q;
    assign v_din        = v_din_q;
    assign v_oce        = 1'b1;
    assign v_reseta     = reset;
    assign v_resetb     = reset;
    assign cpu_wr_ack   = cpu_wr_ack_q;
    assign cpu_rd_valid = cpu_rd_valid_q;
    assign cpu_rd_data  = cpu_rd_data_q;
    assign disp_valid   = disp_valid_q;
    assign disp_data    = disp_data_q;
    assign clear_busy   = clr_busy;
    assign clear_done   = clr_done;

endmodule

// File: tb/tb_vram_ctrl.sv
// Self-checking bench for vram_ctrl with a behavioural VRAM and a shadow memory.
`timescale 1ns/1ps
module tb_vram_ctrl;

    localparam logic [7:0] FILL = 8'h20;

    logic       MEMORY_CLK = 1'b0;
    logic       reset;
    logic       cpu_wr_req, cpu_wr_ack;
    logic [9:0] cpu_wr_addr;
    logic [7:0] cpu_wr_data;
    logic       cpu_rd_req, cpu_rd_valid;
    logic [9:0] cpu_rd_addr;
    logic [7:0] cpu_rd_data;
    logic       disp_req, disp_valid;
    logic [9:0] disp_addr;
    logic [7:0] disp_data;
    logic       clear_start, clear_busy, clear_done;
    logic       v_cea, v_ceb, v_oce, v_reseta, v_resetb;
    logic [9:0] v_ada, v_adb;
    logic [7:0] v_din, v_dout;

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_mem [1024];
    logic [7:0] last_disp_exp = 8'h00;
    logic [7:0] last_cpu_exp  = 8'h00;

    always #5 MEMORY_CLK = ~MEMORY_CLK;

    vram_ctrl #(.FILL_CHAR(FILL)) dut (
        .MEMORY_CLK   (MEMORY_CLK),
        .reset        (reset),
        .cpu_wr_req   (cpu_wr_req),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ack   (cpu_wr_ack),
        .cpu_rd_req   (cpu_rd_req),
        .cpu_rd_addr  (cpu_rd_addr),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_rd_data  (cpu_rd_data),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .v_cea        (v_cea),
        .v_ceb        (v_ceb),
        .v_oce        (v_oce),
        .v_reseta     (v_reseta),
        .v_resetb     (v_resetb),
        .v_ada        (v_ada),
        .v_adb        (v_adb),
        .v_din        (v_din),
        .v_dout       (v_dout)
    );

    function automatic logic [7:0] init_pat(int i);
        return 8'(i * 7 + 3);
    endfunction

    // Synchronous dual-port VRAM, one cycle read latency, preloaded on first edge.
    logic [7:0] vram [1024];
    logic       mem_ready = 1'b0;
    always @(posedge MEMORY_CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) vram[i] <= init_pat(i);
            mem_ready <= 1'b1;
        end else begin
            if (v_cea) vram[v_ada] <= v_din;
            if (v_ceb) v_dout <= vram[v_adb];
        end
    end

    task automatic tick;
        @(posedge MEMORY_CLK);
        #1;
    endtask

    // Holds a CPU write request until ack; returns inside the ack cycle.
    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d, output bit got);
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            tick();
            if (cpu_wr_ack) got = 1'b1;
        end
        cpu_wr_req = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cpu_wr_req = 0; cpu_wr_addr = 0; cpu_wr_data = 0;
        cpu_rd_req = 0; cpu_rd_addr = 0; disp_req = 0; disp_addr = 0; clear_start = 0;
        repeat (3) tick();
        checks++;
        if (v_cea !== 1'b0 || v_ceb !== 1'b0 || v_ada !== 10'd0 || v_adb !== 10'd0 ||
            v_din !== 8'd0)
            begin errors++; $display("FAIL reset_vram_if: cea=%b ceb=%b ada=%h adb=%h din=%h expected all 0",
                v_cea, v_ceb, v_ada, v_adb, v_din); end
        checks++;
        if (cpu_wr_ack !== 1'b0 || cpu_rd_valid !== 1'b0 || disp_valid !== 1'b0 ||
            clear_busy !== 1'b0 || clear_done !== 1'b0)
            begin errors++; $display("FAIL reset_pulses: ack=%b crv=%b dv=%b busy=%b done=%b expected 0",
                cpu_wr_ack, cpu_rd_valid, disp_valid, clear_busy, clear_done); end
        checks++;
        if (cpu_rd_data !== 8'h00 || disp_data !== 8'h00)
            begin errors++; $display("FAIL reset_rd_data: cpu=%h disp=%h expected 00", cpu_rd_data, disp_data); end
        checks++;
        if (v_oce !== 1'b1 || v_reseta !== 1'b1 || v_resetb !== 1'b1)
            begin errors++; $display("FAIL reset_ties: oce=%b ra=%b rb=%b expected 1 1 1", v_oce, v_reseta, v_resetb); end
        reset = 1'b0;
        tick();
        checks++;
        if (v_reseta !== 1'b0 || v_resetb !== 1'b0 || v_oce !== 1'b1)
            begin errors++; $display("FAIL reset_release: ra=%b rb=%b oce=%b expected 0 0 1", v_reseta, v_resetb, v_oce); end
    endtask

    task automatic test_write_basic;
        cpu_wr_req = 1'b1; cpu_wr_addr = 10'h041; cpu_wr_data = 8'h48;
        checks++;
        if (v_cea !== 1'b0 || cpu_wr_ack !== 1'b0)
            begin errors++; $display("FAIL wr_grant_cycle: cea=%b ack=%b expected 0 0", v_cea, cpu_wr_ack); end
        tick();
        checks++;
        if (v_cea !== 1'b1 || v_ada !== 10'h041 || v_din !== 8'h48 || cpu_wr_ack !== 1'b1)
            begin errors++; $display("FAIL wr_basic: cea=%b ada=%h din=%h ack=%b expected 1 041 48 1",
                v_cea, v_ada, v_din, cpu_wr_ack); end
        cpu_wr_req = 1'b0;
        ref_mem[10'h041] = 8'h48;
        tick();
        checks++;
        if (v_cea !== 1'b0 || cpu_wr_ack !== 1'b0)
            begin errors++; $display("FAIL wr_one_shot: cea=%b ack=%b expected 0 0", v_cea, cpu_wr_ack); end
    endtask

    task automatic test_disp_read;
        disp_req = 1'b1; disp_addr = 10'h041;
        for (int k = 1; k <= 4; k++) begin
            tick();
            disp_req = 1'b0;
            checks++;
            if (disp_valid !== (k == 3))
                begin errors++; $display("FAIL disp_latency +%0d: valid=%b expected %b", k, disp_valid, k == 3); end
            if (k >= 3) begin
                checks++;
                if (disp_data !== 8'h48)
                    begin errors++; $display("FAIL disp_data +%0d: got %h expected 48", k, disp_data); end
            end
        end
        last_disp_exp = 8'h48;
    endtask

    task automatic test_concurrent;
        bit got;
        cpu_write(10'h000, 8'h3C, got);
        checks++;
        if (!got) begin errors++; $display("FAIL conc_wr0: no ack got=%b expected 1", got); end
        cpu_write(10'h3FF, 8'hC3, got);
        checks++;
        if (!got) begin errors++; $display("FAIL conc_wr1: no ack got=%b expected 1", got); end
        tick();
        disp_req = 1'b1; disp_addr = 10'h000;
        cpu_rd_req = 1'b1; cpu_rd_addr = 10'h3FF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            disp_req = 1'b0;
            checks++;
            if (disp_valid !== (k == 3) || cpu_rd_valid !== (k == 4))
                begin errors++; $display("FAIL conc_valid +%0d: dv=%b cv=%b expected %b %b",
                    k, disp_valid, cpu_rd_valid, k == 3, k == 4); end
            if (k == 3) begin
                checks++;
                if (disp_data !== ref_mem[0])
                    begin errors++; $display("FAIL conc_disp_data: got %h expected %h", disp_data, ref_mem[0]); end
            end
            if (k == 4) begin
                checks++;
                if (cpu_rd_data !== ref_mem[1023])
                    begin errors++; $display("FAIL conc_cpu_data: got %h expected %h", cpu_rd_data, ref_mem[1023]); end
            end
            if (cpu_rd_valid) cpu_rd_req = 1'b0;
        end
        cpu_rd_req = 1'b0;
        last_disp_exp = ref_mem[0];
        last_cpu_exp  = ref_mem[1023];
    endtask

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    // Random display pulses plus CPU reads; strict display priority predicts CPU grant.
    task automatic test_random_reads;
        exp_t q[$];
        bit   cpu_act = 0, cpu_gnt = 0, just_done, exp_dv, exp_cv;
        int   cpu_due = 0;
        logic [7:0] cexp = 8'h00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            just_done = 0;
            exp_dv = (q.size() > 0) && (q[0].due == cyc);
            checks++;
            if (disp_valid !== exp_dv)
                begin errors++; $display("FAIL rnd_disp_valid cyc %0d: got %b expected %b", cyc, disp_valid, exp_dv); end
            if (exp_dv) begin
                last_disp_exp = q[0].data;
                void'(q.pop_front());
            end
            checks++;
            if (disp_data !== last_disp_exp)
                begin errors++; $display("FAIL rnd_disp_data cyc %0d: got %h expected %h", cyc, disp_data, last_disp_exp); end
            exp_cv = cpu_act && cpu_gnt && (cpu_due == cyc);
            checks++;
            if (cpu_rd_valid !== exp_cv)
                begin errors++; $display("FAIL rnd_cpu_valid cyc %0d: got %b expected %b", cyc, cpu_rd_valid, exp_cv); end
            if (exp_cv) begin
                last_cpu_exp = cexp;
                cpu_act = 0; cpu_rd_req = 1'b0; just_done = 1;
            end
            checks++;
            if (cpu_rd_data !== last_cpu_exp)
                begin errors++; $display("FAIL rnd_cpu_data cyc %0d: got %h expected %h", cyc, cpu_rd_data, last_cpu_exp); end
            disp_req = (cyc < 390) && ($urandom_range(0, 2) == 0);
            if (disp_req) begin
                disp_addr = 10'($urandom_range(0, 1023));
                q.push_back('{cyc + 3, ref_mem[disp_addr]});
            end
            if (!cpu_act && !just_done && cyc < 380 && $urandom_range(0, 1) == 1) begin
                cpu_act = 1; cpu_gnt = 0;
                cpu_rd_req = 1'b1;
                cpu_rd_addr = 10'($urandom_range(0, 1023));
                cexp = ref_mem[cpu_rd_addr];
            end
            if (cpu_act && !cpu_gnt && !disp_req) begin
                cpu_gnt = 1; cpu_due = cyc + 3;
            end
            tick();
        end
        disp_req = 1'b0; cpu_rd_req = 1'b0;
    endtask

    task automatic test_random_writes;
        bit got;
        logic [9:0] a, ra;
        logic [7:0] d;
        for (int n = 0; n < 30; n++) begin
            a = 10'($urandom_range(0, 1023));
            d = 8'($urandom_range(0, 255));
            cpu_write(a, d, got);
            checks++;
            if (!got || v_cea !== 1'b1 || v_ada !== a || v_din !== d)
                begin errors++; $display("FAIL rnd_wr %0d: got=%b cea=%b ada=%h din=%h expected 1 1 %h %h",
                    n, got, v_cea, v_ada, v_din, a, d); end
            ra = ($urandom_range(0, 1) == 1) ? a : 10'($urandom_range(0, 1023));
            disp_req = 1'b1; disp_addr = ra;
            repeat (3) begin tick(); disp_req = 1'b0; end
            checks++;
            if (disp_valid !== 1'b1 || disp_data !== ref_mem[ra])
                begin errors++; $display("FAIL rnd_wr_readback %h: valid=%b data=%h expected 1 %h",
                    ra, disp_valid, disp_data, ref_mem[ra]); end
            last_disp_exp = ref_mem[ra];
        end
    endtask

`ifdef VRAM_CLEAR_EN
    task automatic test_clear;
        int  nwr = 0, done_cyc = -1;
        bit  acked = 0;
        logic [7:0] old3ff = ref_mem[1023];
        logic [9:0] ra;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        checks++;
        if (clear_busy !== 1'b1)
            begin errors++; $display("FAIL clr_busy_start: got %b expected 1", clear_busy); end
        for (int rel = 1; rel < 1200 && !acked; rel++) begin
            if (rel == 5) begin
                cpu_wr_req = 1'b1; cpu_wr_addr = 10'h123; cpu_wr_data = 8'hA5;
            end
            if (rel == 10) begin disp_req = 1'b1; disp_addr = 10'h3FF; end
            if (rel == 11) disp_req = 1'b0;
            if (rel == 13) begin
                checks++;
                if (disp_valid !== 1'b1 || disp_data !== old3ff)
                    begin errors++; $display("FAIL clr_disp_read: valid=%b data=%h expected 1 %h",
                        disp_valid, disp_data, old3ff); end
                last_disp_exp = old3ff;
            end
            if (v_cea && !cpu_wr_ack) begin
                checks++;
                if (v_ada !== nwr[9:0] || v_din !== FILL)
                    begin errors++; $display("FAIL clr_write %0d: ada=%h din=%h expected %h %h",
                        nwr, v_ada, v_din, nwr[9:0], FILL); end
                nwr++;
            end
            if (clear_done) begin
                done_cyc = rel;
                checks++;
                if (nwr != 1024 || v_cea !== 1'b1)
                    begin errors++; $display("FAIL clr_done: writes=%0d cea=%b expected 1024 1", nwr, v_cea); end
            end
            if (cpu_wr_ack) begin
                acked = 1;
                cpu_wr_req = 1'b0;
                checks++;
                if (rel != done_cyc + 1 || v_ada !== 10'h123 || v_din !== 8'hA5 || clear_busy !== 1'b0)
                    begin errors++; $display("FAIL clr_cpu_ack: cyc=%0d ada=%h din=%h busy=%b expected %0d 123 a5 0",
                        rel, v_ada, v_din, clear_busy, done_cyc + 1); end
            end
            if (!acked) tick();
        end
        cpu_wr_req = 1'b0;
        checks++;
        if (!acked || nwr != 1024)
            begin errors++; $display("FAIL clr_timeout: acked=%b writes=%0d expected 1 1024", acked, nwr); end
        for (int i = 0; i < 1024; i++) ref_mem[i] = FILL;
        ref_mem[10'h123] = 8'hA5;
        for (int n = 0; n < 9; n++) begin
            ra = (n == 0) ? 10'h123 : 10'($urandom_range(0, 1023));
            disp_req = 1'b1; disp_addr = ra;
            repeat (3) begin tick(); disp_req = 1'b0; end
            checks++;
            if (disp_valid !== 1'b1 || disp_data !== ref_mem[ra])
                begin errors++; $display("FAIL clr_readback %h: valid=%b data=%h expected 1 %h",
                    ra, disp_valid, disp_data, ref_mem[ra]); end
            last_disp_exp = ref_mem[ra];
        end
        tick();
        checks++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0)
            begin errors++; $display("FAIL clr_idle: busy=%b done=%b expected 0 0", clear_busy, clear_done); end
    endtask

    task automatic test_clear_reset;
        bit saw_wr = 0, saw_done = 0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (500) tick();
        // Counter now 500; the write for 499 is on the bus.
        checks++;
        if (v_cea !== 1'b1 || v_ada !== 10'd499 || clear_busy !== 1'b1)
            begin errors++; $display("FAIL clr_rst_pre: cea=%b ada=%0d busy=%b expected 1 499 1",
                v_cea, v_ada, clear_busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (clear_busy !== 1'b0 || v_cea !== 1'b0 || disp_data !== 8'h00)
            begin errors++; $display("FAIL clr_rst_abort: busy=%b cea=%b ddata=%h expected 0 0 00",
                clear_busy, v_cea, disp_data); end
        for (int k = 0; k < 1100; k++) begin
            tick();
            if (v_cea) saw_wr = 1;
            if (clear_done || clear_busy) saw_done = 1;
        end
        checks++;
        if (saw_wr || saw_done)
            begin errors++; $display("FAIL clr_rst_after: writes=%b done_or_busy=%b expected 0 0", saw_wr, saw_done); end
    endtask
`else
    task automatic test_clear_disabled;
        bit saw = 0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (v_cea || clear_busy || clear_done) saw = 1;
            tick();
        end
        checks++;
        if (saw)
            begin errors++; $display("FAIL clr_disabled: activity=%b expected 0", saw); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_pat(i);
        test_reset();
        test_write_basic();
        test_disp_read();
        test_concurrent();
        test_random_reads();
        test_random_writes();
`ifdef VRAM_CLEAR_EN
        test_clear();
        test_clear_reset();
`else
        test_clear_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
